// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider producing quotient (lo) and remainder (hi)
//   clk         rising-edge system clock
//   reset       asynchronous active-low reset
//   start       division request, sampled only while idle
//   a, b        dividend and divisor, captured on the accepted start edge
//   busy        high while the division is running or being finalised
//   done        one-cycle completion pulse
//   div_by_zero divisor-zero flag, valid with done, held until the next accepted start
//   hi, lo      remainder and quotient, held until the next completion
// Optional build macro DIV_SEQ_SIGNED_EN selects two's-complement operands.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;
  stateT state;
  logic [4:0] count;
  logic zeroFlag;
  logic [WIDTH-1:0] quot, rem, divisor, aMag, bMag, quotOut, remOut;
  logic [WIDTH:0] partial, diff;
  // quot shifts dividend bits out at the top and quotient bits in at the bottom;
  // diff[WIDTH] is the borrow of the trial subtract
  always_comb begin
    partial = {rem, quot[WIDTH-1]};
    diff = partial - {1'b0, divisor};
  end
`ifdef DIV_SEQ_SIGNED_EN
  logic negQ, negR;
  // magnitudes go through the unsigned core; signs are restored on the way out
  always_comb begin
    aMag = a[WIDTH-1] ? -a : a;
    bMag = b[WIDTH-1] ? -b : b;
    quotOut = negQ ? -quot : quot;
    remOut = negR ? -rem : rem;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      negQ <= 1'b0;
      negR <= 1'b0;
    end else if (state == IDLE && start) begin
      negQ <= a[WIDTH-1] ^ b[WIDTH-1];
      negR <= a[WIDTH-1];
    end
  end
`else
  always_comb begin
    aMag = a;
    bMag = b;
    quotOut = quot;
    remOut = rem;
  end
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      zeroFlag <= 1'b0;
      quot <= '0;
      rem <= '0;
      divisor <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          quot <= aMag;
          rem <= '0;
          divisor <= bMag;
          count <= '0;
          zeroFlag <= (b == '0);
          div_by_zero <= 1'b0;
          busy <= 1'b1;
          state <= (b == '0) ? FIX : RUN;
        end
        RUN: begin
          quot <= {quot[WIDTH-2:0], ~diff[WIDTH]};
          rem <= diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
          count <= count + 5'd1;
          if (count == 5'd31) state <= FIX;
        end
        FIX: begin
          // a zero divisor leaves the previous hi/lo untouched
          if (!zeroFlag) begin
            hi <= remOut;
            lo <= quotOut;
          end
          div_by_zero <= zeroFlag;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq with a result scoreboard and cycle model
module tb_div_seq;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic busy, done, div_by_zero;
  logic [31:0] hi, lo;
  typedef struct {
    logic [31:0] a, b, lo, hi;
    logic dbz;
  } vec_t;
  vec_t q[$];
  vec_t tbl[11];
  int checks = 0, fails = 0, remCyc = 0;
  bit finishing = 0, justAcc = 0;
  logic [31:0] heldLo = '0, heldHi = '0;
  logic heldDbz = 1'b0;

  div_seq dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // cycle model: 33 edges per division, 1 edge for a zero divisor, start ignored while busy
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      remCyc = 0;
      finishing = 0;
      justAcc = 0;
    end else begin
      finishing = (remCyc == 1);
      justAcc = 0;
      if (remCyc != 0) remCyc--;
      else if (start) begin
        remCyc = (b == 0) ? 1 : 33;
        justAcc = 1;
      end
    end
  end

  always @(negedge clk) begin
    vec_t e;
    if (!reset) begin
      heldLo = '0;
      heldHi = '0;
      heldDbz = 1'b0;
    end else begin
      if (justAcc) heldDbz = 1'b0;
      if (finishing) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL scoreboard: completion with no expected result at %0t", $time);
        end else begin
          e = q.pop_front();
          heldLo = e.lo;
          heldHi = e.hi;
          heldDbz = e.dbz;
        end
      end
      check("busy", {31'd0, busy}, {31'd0, remCyc != 0});
      check("done", {31'd0, done}, {31'd0, finishing});
      check("div_by_zero", {31'd0, div_by_zero}, {31'd0, heldDbz});
      check("lo", lo, heldLo);
      check("hi", hi, heldHi);
    end
  end

  task automatic waitEmpty(input string name);
    for (int i = 0; i < 80 && q.size() != 0; i++) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
    end
    if (q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL %s: result not delivered, %0d pending, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic runOp(input vec_t v);
    @(negedge clk);
    a = v.a;
    b = v.b;
    start = 1'b1;
    q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    waitEmpty("op");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    tbl[1]  = '{32'd5, 32'd0, 32'd14, 32'd2, 1'b1};
`ifdef DIV_SEQ_SIGNED_EN
    tbl[2]  = '{32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    tbl[3]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0};
    tbl[5]  = '{32'hDEADBEEF, 32'h10, 32'hFDEADBEF, 32'hFFFFFFFF, 1'b0};
    tbl[10] = '{32'd1000000, 32'hFFFFFFF9, 32'hFFFDD1F7, 32'd1, 1'b0};
`else
    tbl[2]  = '{32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0};
    tbl[3]  = '{32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0};
    tbl[5]  = '{32'hDEADBEEF, 32'h10, 32'h0DEADBEE, 32'hF, 1'b0};
    tbl[10] = '{32'd1000000, 32'hFFFFFFF9, 32'd0, 32'd1000000, 1'b0};
`endif
    tbl[4]  = '{32'd3, 32'd10, 32'd0, 32'd3, 1'b0};
    tbl[6]  = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
    tbl[7]  = '{32'd12345, 32'd12345, 32'd1, 32'd0, 1'b0};
    tbl[8]  = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
    tbl[9]  = '{32'd7, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1};
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset hi", hi, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 11; i++) runOp(tbl[i]);
    // reset in the middle of a division: immediate clear, no completion
    @(negedge clk);
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    q.push_back('{32'd100, 32'd7, 32'd14, 32'd2, 1'b0});
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort div_by_zero", {31'd0, div_by_zero}, 32'd0);
    check("abort lo", lo, 32'd0);
    check("abort hi", hi, 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    runOp('{32'd9, 32'd3, 32'd3, 32'd0, 1'b0});
    // start during RUN is ignored; start held into the done cycle is accepted
    @(negedge clk);
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    q.push_back('{32'd100, 32'd7, 32'd14, 32'd2, 1'b0});
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = 32'd1000;
    b = 32'd10;
    start = 1'b1;
    q.push_back('{32'd1000, 32'd10, 32'd100, 32'd0, 1'b0});
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    waitEmpty("back-to-back");
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
